irq_ctrl: RTL and testbench
===========================

Name: irq_ctrl

Overview:
- Parametrised interrupt controller between external interrupt lines and the pipelined mips core. Successor to the core's single `interrupter` input.
- Provides N synchronised sources, each configured as edge- or level-sensitive.
- Adds a mask register, pending latches and fixed priority (lowest index wins).
- Uses a req/ack/eret handshake with the core's exception logic, so the core always sees one stable, identified interrupt at a time.

Parameters:
- N_SRC, 4, number of interrupt sources (1..32).
- ID_W, 2, width of irq_id; must satisfy 2**ID_W >= N_SRC.
- EDGE_MASK, 4'b0011, per-source mode: bit=1 rising-edge, bit=0 level-high.
- SYNC_STAGES, 2, synchroniser depth on irq_in (>=2).
- MASK_RST, all ones, reset value of mask register.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- irq_in  input  N_SRC  raw asynchronous interrupt lines.
- mask_we  input  1  write-enable for mask register.
- mask_wdata  input  N_SRC  new mask value (1 = enabled).
- mask_q  output  N_SRC  current mask register.
- pending_q  output  N_SRC  current pending latches.
- irq_req  output  1  interrupt request to core.
- irq_id  output  ID_W  index of requested/serviced source.
- irq_ack  input  1  core accepts request (1-cycle pulse).
- eret  input  1  core finished handler (1-cycle pulse).
- in_service  output  1  handler active.

Behaviour:
- Reset (async, immediate): sync chain=0, edge history=0, pending_q=0, mask_q=MASK_RST, state=IDLE, irq_req=0, irq_id=0, in_service=0.
- Synchroniser:
  - irq_in passes through SYNC_STAGES flops, giving s[i].
  - Edge sources keep a 1-flop history h[i].
  - Rising edge is s[i]&~h[i].
- Pending, edge source: set on rising edge; cleared on accepted ack with irq_id==i. If set and clear occur in the same cycle, set wins and the bit stays 1.
- Pending, level source: pending[i] = s[i] registered each cycle. Ack does not clear it; the handler must remove the cause.
- Masking: mask gates request eligibility only. Masked sources still accumulate pending. Mask write takes effect the cycle after mask_we.
- eligible = pending_q & mask_q. Winner = lowest set index.
- State machine, 3 states:
  - IDLE: irq_req=0. If eligible != 0, go to REQ and register irq_id=winner.
  - REQ: irq_req=1; irq_id is held stable and is not re-arbitrated even if a higher-priority source arrives.
    - irq_ack=1: go to SERVICE and clear the edge pending bit.
    - else if eligible[irq_id]==0 (masked off or level dropped): withdraw to IDLE, irq_req=0 next cycle.
    - If ack and withdrawal coincide, ack wins.
  - SERVICE: in_service=1, irq_req=0, irq_id held. No nesting. eret=1 returns to IDLE; re-arbitration starts the following cycle.
- irq_ack outside REQ and eret outside SERVICE are ignored, with no state change.
- Latency for an edge source (SYNC_STAGES=2), with irq_in rising before edge k:
  - s high after edge k+1.
  - pending after edge k+2.
  - irq_req high after edge k+3.
- Minimum gap eret→next irq_req: 1 cycle in IDLE.
- Reset mid-operation: all state drops immediately. irq_req falls asynchronously, and pending edges in flight are lost.
- Edge pulses shorter than one clk period are not guaranteed to be captured.

Test Plan:
1. Reset mid-REQ:
   - Assert rst while irq_req=1 → irq_req, pending_q, in_service all 0 without waiting for clk.
   - mask_q returns to 4'b1111.
2. Single edge:
   - Stimulus: irq_in[1] pulses 0→1 for 2 cycles.
   - Required: irq_req=1, irq_id=1 three cycles later.
   - Ack → in_service=1, pending_q[1]=0.
   - eret → IDLE, no further req.
3. Priority:
   - Stimulus: irq_in[3] (level) and irq_in[0] (edge) rise together.
   - Required: irq_id=0 first.
   - After ack+eret, irq_id=3 is requested while irq_in[3] stays high.
4. Mask withdraw:
   - Stimulus: in REQ for id=2, write mask_wdata=4'b1011.
   - Required: irq_req drops the cycle after mask updates and pending_q[2] stays 1.
   - Re-enable mask → irq_req returns with id=2.
5. Collision:
   - Stimulus: new rising edge on irq_in[0] synchronised in the same cycle as ack for id=0.
   - Required: pending_q[0] remains 1, and a second request for id=0 follows eret.
6. Spurious handshake:
   - Stimulus: irq_ack in IDLE and eret in REQ.
   - Required: no state change, irq_req and irq_id unaffected.

Source files
------------

// File: rtl/irq_ctrl.sv
// ---------------------------------------------------------------------------
// irq_ctrl -- interrupt controller that sits between the external interrupt
// lines and the core's exception logic.
//
// Each source line is synchronised first. Edge sources (EDGE_MASK bit = 1)
// latch a pending bit on a rising edge. Level sources (bit = 0) follow the
// synchronised line. The mask gates eligibility only, so masked sources still
// accumulate pending state. Arbitration uses fixed priority, and the lowest
// index wins. The winning source is presented to the core through a
// req/ack/eret handshake.
//
// Handshake: irq_req is high in REQ with irq_id held stable. A 1-cycle
// irq_ack while irq_req=1 accepts the request and moves the controller to
// SERVICE. A 1-cycle eret while in_service=1 returns it to IDLE. An ack
// outside REQ is ignored, and so is an eret outside SERVICE. The request is
// withdrawn when its source stops being eligible before the core acks it. If
// the ack and the withdrawal happen in the same cycle, the ack wins.
//
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous active-high reset
//   irq_in      raw asynchronous interrupt lines
//   mask_we     mask register write enable
//   mask_wdata  new mask value (1 = enabled)
//   mask_q      current mask register
//   pending_q   current pending latches
//   irq_req     interrupt request to the core
//   irq_id      index of the requested/serviced source
//   irq_ack     core accepts the request (1-cycle pulse)
//   eret        core finished the handler (1-cycle pulse)
//   in_service  handler active
// ---------------------------------------------------------------------------
module irq_ctrl #(
    parameter int                N_SRC       = 4,
    parameter int                ID_W        = 2,
    parameter logic [N_SRC-1:0]  EDGE_MASK   = 4'b0011,
    parameter int                SYNC_STAGES = 2,
    parameter logic [N_SRC-1:0]  MASK_RST    = '1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_SRC-1:0] irq_in,
    input  logic             mask_we,
    input  logic [N_SRC-1:0] mask_wdata,
    output logic [N_SRC-1:0] mask_q,
    output logic [N_SRC-1:0] pending_q,
    output logic             irq_req,
    output logic [ID_W-1:0]  irq_id,
    input  logic             irq_ack,
    input  logic             eret,
    output logic             in_service
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REQ     = 2'd1,
        S_SERVICE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ID_W-1:0]   irq_id_q, irq_id_d;
    logic [N_SRC-1:0]  sync_q [SYNC_STAGES];
    logic [N_SRC-1:0]  sync_d [SYNC_STAGES];
    logic [N_SRC-1:0]  hist_q, hist_d;
    logic [N_SRC-1:0]  pending_d;
    logic [N_SRC-1:0]  mask_d;

    logic [N_SRC-1:0]  sync_s;
    logic [N_SRC-1:0]  rise;
    logic [N_SRC-1:0]  ack_clr;
    logic [N_SRC-1:0]  eligible;
    logic [ID_W-1:0]   winner;
    logic              cur_eligible;
    logic              ack_accept;

    // Synchroniser chain: stage 0 samples the raw line. The last stage is
    // the clean copy used by all the logic below.
    always_comb begin
        sync_d[0] = irq_in;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    assign sync_s = sync_q[SYNC_STAGES-1];

    // The history flop is only meaningful for edge sources. Level bits stay 0.
    assign hist_d = sync_s & EDGE_MASK;
    assign rise   = sync_s & ~hist_q & EDGE_MASK;

    assign ack_accept = (state_q == S_REQ) && irq_ack;

    // The pending bit clears only for the edge source that is being acked.
    always_comb begin
        ack_clr = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (ack_accept && (irq_id_q == ID_W'(i)) && EDGE_MASK[i]) begin
                ack_clr[i] = 1'b1;
            end
        end
    end

    // The set term is ORed after the clear, so a new edge that arrives in
    // the same cycle as the ack is kept.
    assign pending_d = (EDGE_MASK & (rise | (pending_q & ~ack_clr)))
                     | (~EDGE_MASK & sync_s);

    assign mask_d   = mask_we ? mask_wdata : mask_q;
    assign eligible = pending_q & mask_q;

    // Fixed priority: scanning downwards lets the lowest index overwrite.
    always_comb begin
        winner = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                winner = ID_W'(i);
            end
        end
    end

    // Eligibility of the source currently held in irq_id_q.
    always_comb begin
        cur_eligible = 1'b0;
        for (int i = 0; i < N_SRC; i++) begin
            if (irq_id_q == ID_W'(i)) begin
                cur_eligible = eligible[i];
            end
        end
    end

    // Next-state logic. irq_id is captured only on IDLE->REQ. From that point
    // it is frozen until the controller returns to IDLE and re-arbitrates.
    always_comb begin
        state_d  = state_q;
        irq_id_d = irq_id_q;
        unique case (state_q)
            S_IDLE: begin
                if (|eligible) begin
                    state_d  = S_REQ;
                    irq_id_d = winner;
                end
            end
            S_REQ: begin
                if (irq_ack) begin
                    state_d = S_SERVICE;
                end else if (!cur_eligible) begin
                    state_d = S_IDLE;
                end
            end
            S_SERVICE: begin
                if (eret) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            hist_q    <= '0;
            pending_q <= '0;
            mask_q    <= MASK_RST;
            state_q   <= S_IDLE;
            irq_id_q  <= '0;
        end else begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_d[i];
            end
            hist_q    <= hist_d;
            pending_q <= pending_d;
            mask_q    <= mask_d;
            state_q   <= state_d;
            irq_id_q  <= irq_id_d;
        end
    end

    // The outputs decode straight from the state register. A reset therefore
    // drops irq_req and in_service immediately, without a clock edge.
    assign irq_req    = (state_q == S_REQ);
    assign in_service = (state_q == S_SERVICE);
    assign irq_id     = irq_id_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_irq_ctrl -- self-checking bench for irq_ctrl (default parameters:
// 4 sources, sources 0/1 edge, sources 2/3 level, 2 sync stages).
// Observed word: {irq_req, irq_id[1:0], in_service, pending_q[3:0], mask_q[3:0]}.
// ---------------------------------------------------------------------------
module tb_irq_ctrl;

    logic       clk;
    logic       rst;
    logic [3:0] irq_in;
    logic       mask_we;
    logic [3:0] mask_wdata;
    logic [3:0] mask_q;
    logic [3:0] pending_q;
    logic       irq_req;
    logic [1:0] irq_id;
    logic       irq_ack;
    logic       eret;
    logic       in_service;

    irq_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .irq_in     (irq_in),
        .mask_we    (mask_we),
        .mask_wdata (mask_wdata),
        .mask_q     (mask_q),
        .pending_q  (pending_q),
        .irq_req    (irq_req),
        .irq_id     (irq_id),
        .irq_ack    (irq_ack),
        .eret       (eret),
        .in_service (in_service)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // scoreboard
    logic [11:0] exp_q[$];
    string       name_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;

    typedef struct {
        logic [3:0]  irq_in;
        logic        mask_we;
        logic [3:0]  mask_wdata;
        logic        ack;
        logic        eret;
        logic [11:0] exp;
    } vec_t;

    vec_t vecs[9];

    function automatic logic [11:0] pk(input logic req, input logic [1:0] id,
                                       input logic svc, input logic [3:0] pend,
                                       input logic [3:0] msk);
        return {req, id, svc, pend, msk};
    endfunction

    task automatic expect_out(input logic [11:0] e, input string nm);
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic compare_out();
        logic [11:0] e;
        logic [11:0] got;
        string       nm;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_empty: got nothing to compare, required one entry");
        end else begin
            e   = exp_q.pop_front();
            nm  = name_q.pop_front();
            got = {irq_req, irq_id, in_service, pending_q, mask_q};
            n_checks++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL %s: got req=%b id=%0d svc=%b pend=%b mask=%b, required req=%b id=%0d svc=%b pend=%b mask=%b",
                         nm, got[11], got[10:9], got[8], got[7:4], got[3:0],
                         e[11], e[10:9], e[8], e[7:4], e[3:0]);
            end
        end
    endtask

    // driver: apply inputs, push the expectation, take one clock edge, compare
    task automatic step(input logic [3:0] in_v, input logic mwe, input logic [3:0] mwd,
                        input logic ack, input logic er, input logic [11:0] e,
                        input string nm);
        irq_in     = in_v;
        mask_we    = mwe;
        mask_wdata = mwd;
        irq_ack    = ack;
        eret       = er;
        expect_out(e, nm);
        @(posedge clk);
        #2;
        compare_out();
    endtask

    initial begin
        rst        = 1'b1;
        irq_in     = '0;
        mask_we    = 1'b0;
        mask_wdata = '0;
        irq_ack    = 1'b0;
        eret       = 1'b0;

        // reset state
        repeat (2) @(posedge clk);
        #2;
        expect_out(pk(0, 2'd0, 0, 4'b0000, 4'b1111), "reset_state");
        compare_out();
        rst = 1'b0;

        // single edge on source 1, ack, eret, then a spurious ack in IDLE
        vecs[0] = '{4'b0010, 1'b0, 4'h0, 1'b0, 1'b0, pk(0, 2'd0, 0, 4'b0000, 4'b1111)};
        vecs[1] = '{4'b0010, 1'b0, 4'h0, 1'b0, 1'b0, pk(0, 2'd0, 0, 4'b0000, 4'b1111)};
        vecs[2] = '{4'b0000, 1'b0, 4'h0, 1'b0, 1'b0, pk(0, 2'd0, 0, 4'b0010, 4'b1111)};
        vecs[3] = '{4'b0000, 1'b0, 4'h0, 1'b0, 1'b0, pk(1, 2'd1, 0, 4'b0010, 4'b1111)};
        vecs[4] = '{4'b0000, 1'b0, 4'h0, 1'b1, 1'b0, pk(0, 2'd1, 1, 4'b0000, 4'b1111)};
        vecs[5] = '{4'b0000, 1'b0, 4'h0, 1'b0, 1'b0, pk(0, 2'd1, 1, 4'b0000, 4'b1111)};
        vecs[6] = '{4'b0000, 1'b0, 4'h0, 1'b0, 1'b1, pk(0, 2'd1, 0, 4'b0000, 4'b1111)};
        vecs[7] = '{4'b0000, 1'b0, 4'h0, 1'b0, 1'b0, pk(0, 2'd1, 0, 4'b0000, 4'b1111)};
        vecs[8] = '{4'b0000, 1'b0, 4'h0, 1'b1, 1'b0, pk(0, 2'd1, 0, 4'b0000, 4'b1111)};
        for (int i = 0; i < 9; i++) begin
            step(vecs[i].irq_in, vecs[i].mask_we, vecs[i].mask_wdata,
                 vecs[i].ack, vecs[i].eret, vecs[i].exp, $sformatf("edge_vec%0d", i));
        end

        // priority: level 3 and edge 0 together, 0 first, then 3; eret in REQ ignored
        step(4'b1001, 0, 4'h0, 0, 0, pk(0, 2'd1, 0, 4'b0000, 4'b1111), "prio_sync0");
        step(4'b1001, 0, 4'h0, 0, 0, pk(0, 2'd1, 0, 4'b0000, 4'b1111), "prio_sync1");
        step(4'b1001, 0, 4'h0, 0, 0, pk(0, 2'd1, 0, 4'b1001, 4'b1111), "prio_pending");
        step(4'b1001, 0, 4'h0, 0, 0, pk(1, 2'd0, 0, 4'b1001, 4'b1111), "prio_req0");
        step(4'b1001, 0, 4'h0, 1, 0, pk(0, 2'd0, 1, 4'b1000, 4'b1111), "prio_ack0");
        step(4'b1001, 0, 4'h0, 0, 1, pk(0, 2'd0, 0, 4'b1000, 4'b1111), "prio_eret0");
        step(4'b1001, 0, 4'h0, 0, 0, pk(1, 2'd3, 0, 4'b1000, 4'b1111), "prio_req3");
        step(4'b1001, 0, 4'h0, 0, 1, pk(1, 2'd3, 0, 4'b1000, 4'b1111), "spurious_eret");
        step(4'b1001, 0, 4'h0, 1, 0, pk(0, 2'd3, 1, 4'b1000, 4'b1111), "prio_ack3");
        step(4'b0000, 0, 4'h0, 0, 0, pk(0, 2'd3, 1, 4'b1000, 4'b1111), "lvl_drop0");
        step(4'b0000, 0, 4'h0, 0, 0, pk(0, 2'd3, 1, 4'b1000, 4'b1111), "lvl_drop1");
        step(4'b0000, 0, 4'h0, 0, 0, pk(0, 2'd3, 1, 4'b0000, 4'b1111), "lvl_drop2");
        step(4'b0000, 0, 4'h0, 0, 1, pk(0, 2'd3, 0, 4'b0000, 4'b1111), "prio_eret3");
        step(4'b0000, 0, 4'h0, 0, 0, pk(0, 2'd3, 0, 4'b0000, 4'b1111), "prio_idle");

        // mask withdraw on level source 2, then re-enable
        step(4'b0100, 0, 4'h0, 0, 0, pk(0, 2'd3, 0, 4'b0000, 4'b1111), "mask_sync0");
        step(4'b0100, 0, 4'h0, 0, 0, pk(0, 2'd3, 0, 4'b0000, 4'b1111), "mask_sync1");
        step(4'b0100, 0, 4'h0, 0, 0, pk(0, 2'd3, 0, 4'b0100, 4'b1111), "mask_pending");
        step(4'b0100, 0, 4'h0, 0, 0, pk(1, 2'd2, 0, 4'b0100, 4'b1111), "mask_req2");
        step(4'b0100, 1, 4'b1011, 0, 0, pk(1, 2'd2, 0, 4'b0100, 4'b1011), "mask_write");
        step(4'b0100, 0, 4'h0, 0, 0, pk(0, 2'd2, 0, 4'b0100, 4'b1011), "mask_withdraw");
        step(4'b0100, 0, 4'h0, 0, 0, pk(0, 2'd2, 0, 4'b0100, 4'b1011), "mask_hold");
        step(4'b0100, 1, 4'b1111, 0, 0, pk(0, 2'd2, 0, 4'b0100, 4'b1111), "mask_reenable");
        step(4'b0100, 0, 4'h0, 0, 0, pk(1, 2'd2, 0, 4'b0100, 4'b1111), "mask_rereq2");
        step(4'b0100, 0, 4'h0, 1, 0, pk(0, 2'd2, 1, 4'b0100, 4'b1111), "mask_ack2");
        step(4'b0000, 0, 4'h0, 0, 0, pk(0, 2'd2, 1, 4'b0100, 4'b1111), "mask_drop0");
        step(4'b0000, 0, 4'h0, 0, 0, pk(0, 2'd2, 1, 4'b0100, 4'b1111), "mask_drop1");
        step(4'b0000, 0, 4'h0, 0, 0, pk(0, 2'd2, 1, 4'b0000, 4'b1111), "mask_drop2");
        step(4'b0000, 0, 4'h0, 0, 1, pk(0, 2'd2, 0, 4'b0000, 4'b1111), "mask_eret");
        step(4'b0000, 0, 4'h0, 0, 0, pk(0, 2'd2, 0, 4'b0000, 4'b1111), "mask_idle");

        // collision: a second edge on source 0 is synchronised in the ack cycle
        step(4'b0001, 0, 4'h0, 0, 0, pk(0, 2'd2, 0, 4'b0000, 4'b1111), "col_sync0");
        step(4'b0001, 0, 4'h0, 0, 0, pk(0, 2'd2, 0, 4'b0000, 4'b1111), "col_sync1");
        step(4'b0000, 0, 4'h0, 0, 0, pk(0, 2'd2, 0, 4'b0001, 4'b1111), "col_pending");
        step(4'b0001, 0, 4'h0, 0, 0, pk(1, 2'd0, 0, 4'b0001, 4'b1111), "col_req0");
        step(4'b0001, 0, 4'h0, 0, 0, pk(1, 2'd0, 0, 4'b0001, 4'b1111), "col_req_hold");
        step(4'b0000, 0, 4'h0, 1, 0, pk(0, 2'd0, 1, 4'b0001, 4'b1111), "col_ack_set_wins");
        step(4'b0000, 0, 4'h0, 0, 0, pk(0, 2'd0, 1, 4'b0001, 4'b1111), "col_service");
        step(4'b0000, 0, 4'h0, 0, 1, pk(0, 2'd0, 0, 4'b0001, 4'b1111), "col_eret");
        step(4'b0000, 0, 4'h0, 0, 0, pk(1, 2'd0, 0, 4'b0001, 4'b1111), "col_rereq0");
        step(4'b0000, 0, 4'h0, 1, 0, pk(0, 2'd0, 1, 4'b0000, 4'b1111), "col_ack2");
        step(4'b0000, 0, 4'h0, 0, 1, pk(0, 2'd0, 0, 4'b0000, 4'b1111), "col_eret2");
        step(4'b0000, 0, 4'h0, 0, 0, pk(0, 2'd0, 0, 4'b0000, 4'b1111), "col_idle");

        // reset mid-REQ with a non-default mask
        step(4'b0010, 1, 4'b0111, 0, 0, pk(0, 2'd0, 0, 4'b0000, 4'b0111), "rstreq_sync0");
        step(4'b0010, 0, 4'h0, 0, 0, pk(0, 2'd0, 0, 4'b0000, 4'b0111), "rstreq_sync1");
        step(4'b0000, 0, 4'h0, 0, 0, pk(0, 2'd0, 0, 4'b0010, 4'b0111), "rstreq_pending");
        step(4'b0000, 0, 4'h0, 0, 0, pk(1, 2'd1, 0, 4'b0010, 4'b0111), "rstreq_req1");
        #1;
        rst = 1'b1;
        #1;
        expect_out(pk(0, 2'd0, 0, 4'b0000, 4'b1111), "async_reset");
        compare_out();
        #1;
        rst = 1'b0;
        step(4'b0000, 0, 4'h0, 0, 0, pk(0, 2'd0, 0, 4'b0000, 4'b1111), "post_reset0");
        step(4'b0000, 0, 4'h0, 0, 0, pk(0, 2'd0, 0, 4'b0000, 4'b1111), "post_reset1");

        // random mask writes while the controller is idle with nothing pending
        for (int i = 0; i < 4; i++) begin
            logic [3:0] m;
            m = 4'($urandom_range(0, 15));
            step(4'b0000, 1, m, 0, 0, pk(0, 2'd0, 0, 4'b0000, m), $sformatf("rand_mask%0d", i));
        end

        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_leftover: got %0d entries, required 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
